rc_addsub_serial: RTL and testbench
===================================

// Module: rc_addsub_serial
// PURPOSE
//  Multi-cycle, chunk-serial add/subtract unit. Generalises the 4-bit ripple subtractor to
//  WIDTH bits, processing CHUNK bits per clock with a carry/borrow register between chunks.
//  A run-time mode selects add or subtract. A start/busy/done handshake lets it sit behind a
//  controller where a full-width ripple path would not meet timing.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be an integer multiple of CHUNK
//  CHUNK   4  bits processed per cycle; K = WIDTH/CHUNK cycles per operation
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      reset, synchronous, active-high
//  start  in   1      request; sampled only while idle (busy=0)
//  mode   in   1      0 = add (a+b+c), 1 = subtract (a-b-c)
//  a      in   WIDTH  operand A, unsigned / two's complement
//  b      in   WIDTH  operand B
//  c      in   1      carry-in (add) or borrow-in (subtract)
//  busy   out  1      high while an operation is in progress
//  done   out  1      one-cycle pulse: s/co/ovf hold the new result
//  s      out  WIDTH  result, modulo 2^WIDTH
//  co     out  1      carry-out (add) or borrow-out (subtract; 1 iff a < b+c unsigned)
//  ovf    out  1      signed two's-complement overflow of the result
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, s=0, co=0, ovf=0, chunk counter=0.
//  - FSM states:
//    - IDLE: busy=0. start=1 at edge N latches a, b, mode and c into internal registers,
//      clears the counter, and moves to RUN.
//    - RUN: busy=1 from N+1. Edges N+1..N+K each process chunk i (LSB chunk first), where
//      i = counter value. After edge N+K the FSM returns to IDLE.
//  - Latency: done=1 and the result is visible in the cycle after edge N+K (K cycles after
//    acceptance). done is low in every other cycle.
//  - Chunk arithmetic:
//    - Add: {cy', sum} = A_i + B_i + cy, with cy initialised to c.
//    - Subtract: computed as A_i + ~B_i + cy, with cy initialised to ~c.
//      Final borrow-out = ~cy.
//  - s, co and ovf hold the previous result throughout RUN. All three are updated together
//    on the final edge, and hold until the next completion or reset.
//  - ovf rule:
//    - Add: a[MSB]==b[MSB] && s[MSB]!=a[MSB].
//    - Subtract: a[MSB]!=b[MSB] && s[MSB]!=a[MSB].
//    The latched a and b are used, and carry/borrow-in is included in s.
//  - Input handling:
//    - start while busy=1 is ignored.
//    - Changes on a, b, mode or c during RUN have no effect.
//  - Back-to-back: start=1 in the done cycle (FSM is IDLE) is accepted. done and the new
//    busy then overlap for no cycle; busy rises on the following edge.
//  - rst=1 mid-RUN: next edge forces the reset values. The operation is aborted and no
//    done pulse is produced.
//  - rst has priority over start on the same edge.
// TESTING
//  1. W=16,C=4, sub: a=0x0005, b=0x000B, c=0
//     -> done 4 cycles after accept; s=0xFFFA, co=1, ovf=0.
//  2. Sub: a=0x000D, b=0x0003, c=1 -> s=0x0009, co=0, ovf=0.
//     Sub: a=0x8000, b=0x0001, c=0 -> s=0x7FFF, co=0, ovf=1.
//  3. Add: a=0x7FFF, b=0x0001, c=0 -> s=0x8000, co=0, ovf=1.
//     Add: a=0xFFFF, b=0x0001, c=1 -> s=0x0001, co=1, ovf=0.
//  4. Handshake:
//     - start held high with new operands during RUN -> single done, first result only.
//     - start in done cycle -> second op accepted; its done arrives exactly K cycles later.
//  5. rst pulsed at second RUN cycle -> next cycle busy=0, s=0, co=0, ovf=0; no done;
//     a subsequent start works normally.
//  6. W=4,C=1 and W=4,C=4: exhaustive a, b in 0..15, c, mode
//     -> s, co, ovf match a±b±c reference model; latency = W/C.

Source files
------------

// File: rtl/rc_addsub_serial.sv
// Chunk-serial add/subtract unit.
// The operation is spread over WIDTH/CHUNK clocks, least-significant chunk
// first. A single carry register links one chunk to the next. Subtraction
// reuses the adder: the B chunk is inverted and the initial carry is ~c.
module rc_addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int K     = WIDTH / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  // One chunk of ripple addition; the top bit of the result is the carry out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             mode_q, cy_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             load;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum;
  logic             cy_nx;
  logic [WIDTH-1:0] res;

  assign load = (state_q == S_IDLE) && start;

  // Current chunk: operand slice, add with running carry, merge into result.
  always_comb begin
    a_chunk        = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk        = b_q[cnt_q*CHUNK +: CHUNK] ^ {CHUNK{mode_q}};
    {cy_nx, sum}   = chunk_add(a_chunk, b_chunk, cy_q);
    res            = acc_q;
    res[cnt_q*CHUNK +: CHUNK] = sum;
  end

  // FSM next state, chunk counter, and result publication on the last chunk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          s_d     = res;
          // In subtract mode the adder carry is the inverse of the borrow.
          co_d    = cy_nx ^ mode_q;
          if (mode_q)
            ovf_d = (a_q[MSB] != b_q[MSB]) && (res[MSB] != a_q[MSB]);
          else
            ovf_d = (a_q[MSB] == b_q[MSB]) && (res[MSB] != a_q[MSB]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Operand capture at acceptance, then carry/partial result per chunk.
  // These are overwritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      cy_q   <= c ^ mode;
    end else if (state_q == S_RUN) begin
      cy_q   <= cy_nx;
      acc_q  <= res;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rc_addsub_serial.sv
// Bench for rc_addsub_serial: 16/4, 4/1 and 4/4 configurations.
module tb_rc_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st16, md16, c16, busy16, done16, co16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        st41, md41, c41, busy41, done41, co41, ovf41;
  logic [3:0]  a41, b41, s41;
  logic        st44, md44, c44, busy44, done44, co44, ovf44;
  logic [3:0]  a44, b44, s44;

  int n_checks = 0;
  int n_fail   = 0;

  rc_addsub_serial #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .start(st16), .mode(md16), .a(a16), .b(b16), .c(c16),
    .busy(busy16), .done(done16), .s(s16), .co(co16), .ovf(ovf16));
  rc_addsub_serial #(.WIDTH(4), .CHUNK(1)) u41 (
    .clk(clk), .rst(rst), .start(st41), .mode(md41), .a(a41), .b(b41), .c(c41),
    .busy(busy41), .done(done41), .s(s41), .co(co41), .ovf(ovf41));
  rc_addsub_serial #(.WIDTH(4), .CHUNK(4)) u44 (
    .clk(clk), .rst(rst), .start(st44), .mode(md44), .a(a44), .b(b44), .c(c44),
    .busy(busy44), .done(done44), .s(s44), .co(co44), .ovf(ovf44));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic; returns {co, ovf, s}.
  function automatic logic [17:0] model(input int w, input logic m, input logic [15:0] av,
                                        input logic [15:0] bv, input logic cv);
    longint md, ua, ub, uc, full, sa, sb, sr;
    logic [15:0] sv;
    logic cov, ovv;
    md   = longint'(1) << w;
    ua   = longint'(av);
    ub   = longint'(bv);
    uc   = cv ? 64'sd1 : 64'sd0;
    full = m ? (ua - ub - uc) : (ua + ub + uc);
    sv   = 16'(((full % md) + md) % md);
    cov  = m ? (ua < ub + uc) : (full >= md);
    sa   = (ua >= md / 2) ? ua - md : ua;
    sb   = (ub >= md / 2) ? ub - md : ub;
    sr   = m ? (sa - sb - uc) : (sa + sb + uc);
    ovv  = (sr > md / 2 - 1) || (sr < -(md / 2));
    return {cov, ovv, sv};
  endfunction

  // One 16-bit operation; inputs are scrambled while it runs.
  task automatic op16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, output logic [17:0] r, output int lat);
    st16 = 1'b1; md16 = m; a16 = av; b16 = bv; c16 = cv;
    tick;
    st16 = 1'b0;
    check("busy_after_accept", 32'(busy16), 32'd1);
    a16 = 16'($urandom); b16 = 16'($urandom); md16 = 1'($urandom); c16 = 1'($urandom);
    lat = 0;
    while (!done16 && lat < 20) begin
      tick;
      lat++;
    end
    r = {co16, ovf16, s16};
  endtask

  task automatic chk16(input string tag, input logic m, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv);
    logic [17:0] r, e;
    int lat;
    op16(m, av, bv, cv, r, lat);
    e = model(16, m, av, bv, cv);
    check({tag, "_s"},   32'(r[15:0]), 32'(e[15:0]));
    check({tag, "_co"},  32'(r[17]),   32'(e[17]));
    check({tag, "_ovf"}, 32'(r[16]),   32'(e[16]));
    check({tag, "_lat"}, 32'(lat),     32'd4);
  endtask

  task automatic dir16(input string tag, input logic m, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv, input logic [15:0] es,
                       input logic eco, input logic eovf);
    logic [17:0] r;
    int lat;
    op16(m, av, bv, cv, r, lat);
    check({tag, "_s"},   32'(r[15:0]), 32'(es));
    check({tag, "_co"},  32'(r[17]),   32'(eco));
    check({tag, "_ovf"}, 32'(r[16]),   32'(eovf));
    check({tag, "_lat"}, 32'(lat),     32'd4);
  endtask

  // Same operation on both 4-bit configurations in parallel.
  task automatic op4(input logic m, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [17:0] e;
    logic [5:0]  r41, r44;
    int l41, l44, cyc;
    st41 = 1'b1; md41 = m; a41 = av; b41 = bv; c41 = cv;
    st44 = 1'b1; md44 = m; a44 = av; b44 = bv; c44 = cv;
    tick;
    st41 = 1'b0; st44 = 1'b0;
    a41 = ~av; b41 = ~bv; a44 = ~av; b44 = ~bv; md41 = ~m; md44 = ~m;
    l41 = 0; l44 = 0; cyc = 0; r41 = '0; r44 = '0;
    while ((l41 == 0 || l44 == 0) && cyc < 12) begin
      tick;
      cyc++;
      if (done41 && l41 == 0) begin l41 = cyc; r41 = {co41, ovf41, s41}; end
      if (done44 && l44 == 0) begin l44 = cyc; r44 = {co44, ovf44, s44}; end
    end
    e = model(4, m, {12'h0, av}, {12'h0, bv}, cv);
    check("w4c1_s",   32'(r41[3:0]), 32'(e[3:0]));
    check("w4c1_co",  32'(r41[5]),   32'(e[17]));
    check("w4c1_ovf", 32'(r41[4]),   32'(e[16]));
    check("w4c1_lat", 32'(l41),      32'd4);
    check("w4c4_s",   32'(r44[3:0]), 32'(e[3:0]));
    check("w4c4_co",  32'(r44[5]),   32'(e[17]));
    check("w4c4_ovf", 32'(r44[4]),   32'(e[16]));
    check("w4c4_lat", 32'(l44),      32'd1);
  endtask

  initial begin
    logic [17:0] r, e;
    int lat, cyc;
    logic seen;

    rst = 1'b1;
    st16 = 1'b0; md16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    st41 = 1'b0; md41 = 1'b0; a41 = '0; b41 = '0; c41 = 1'b0;
    st44 = 1'b0; md44 = 1'b0; a44 = '0; b44 = '0; c44 = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_s",    32'(s16),    32'd0);
    check("rst_co",   32'(co16),   32'd0);
    check("rst_ovf",  32'(ovf16),  32'd0);
    tick;

    // Directed arithmetic cases.
    dir16("sub1", 1'b1, 16'h0005, 16'h000B, 1'b0, 16'hFFFA, 1'b1, 1'b0);
    dir16("sub2", 1'b1, 16'h000D, 16'h0003, 1'b1, 16'h0009, 1'b0, 1'b0);
    dir16("sub3", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    dir16("add1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir16("add2", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);

    // start held high with changing operands during RUN.
    st16 = 1'b1; md16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0;
    tick;
    cyc = 0;
    while (!done16 && cyc < 20) begin
      a16 = 16'($urandom); b16 = 16'($urandom); md16 = 1'($urandom);
      tick;
      cyc++;
    end
    st16 = 1'b0;
    check("hold_lat", 32'(cyc), 32'd4);
    check("hold_s",   32'(s16), 32'h2345);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done16 || busy16) seen = 1'b1;
    end
    check("hold_single_done", 32'(seen), 32'd0);

    // Back-to-back: second start issued in the done cycle.
    st16 = 1'b1; md16 = 1'b1; a16 = 16'h0100; b16 = 16'h0001; c16 = 1'b0;
    tick;
    st16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 20) begin tick; cyc++; end
    check("b2b_first_s", 32'(s16), 32'h00FF);
    check("b2b_busy_in_done", 32'(busy16), 32'd0);
    st16 = 1'b1; md16 = 1'b0; a16 = 16'h4000; b16 = 16'h4000; c16 = 1'b1;
    tick;
    st16 = 1'b0;
    check("b2b_busy_rise", 32'(busy16), 32'd1);
    check("b2b_no_done",   32'(done16), 32'd0);
    cyc = 0;
    while (!done16 && cyc < 20) begin tick; cyc++; end
    check("b2b_lat", 32'(cyc),   32'd4);
    check("b2b_s",   32'(s16),   32'h8001);
    check("b2b_ovf", 32'(ovf16), 32'd1);
    tick;

    // Reset in the second RUN cycle aborts the operation.
    st16 = 1'b1; md16 = 1'b0; a16 = 16'h0F0F; b16 = 16'h0101; c16 = 1'b0;
    tick;
    st16 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_done", 32'(done16), 32'd0);
    check("abort_s",    32'(s16),    32'd0);
    check("abort_co",   32'(co16),   32'd0);
    check("abort_ovf",  32'(ovf16),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done16) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    chk16("after_abort", 1'b1, 16'h0F0F, 16'h0101, 1'b1);

    // Randomized 16-bit operations against the model.
    for (int i = 0; i < 60; i++) begin
      chk16("rnd", 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      if (($urandom & 1) == 0) tick;
    end

    // Exhaustive 4-bit sweep on both chunkings.
    for (int m = 0; m < 2; m++)
      for (int cv = 0; cv < 2; cv++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++)
            op4(1'(m), 4'(av), 4'(bv), 1'(cv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
